// File: rtl/shift194_sequencer_if.sv
// Upstream word handshake for the shift194 sequencer: parallel word plus valid/ready.
// Latency: none, this file holds signals only.
// Backpressure: the slave side drives din_ready, and a word moves only when din_valid and din_ready are both high.
interface shift194_sequencer_if #(
  parameter int NIBBLES = 2
);
  logic [4*NIBBLES-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/shift194_sequencer.sv
// Drives a 4-bit universal shift register so that out4 emits each accepted word LSB-first, and also gives a bit strobe and a done pulse.
// Latency: word accepted at edge E0, first bit_stb in cycle E1..E2, then one bit per cycle for the frame, and done one cycle after the last strobe.
// Backpressure: din_ready is high only in IDLE and in the final command cycle of a frame. Optional parity bit: define SHIFT194_PARITY_EN.
module shift194_sequencer #(
  parameter int NIBBLES = 2
) (
  input  logic                    cp,
  input  logic                    mr_,
  shift194_sequencer_if.slave     up,
  output logic                    s1,
  output logic                    s0,
  output logic                    p0,
  output logic                    p1,
  output logic                    p2,
  output logic                    p3,
  output logic                    dsr,
  output logic                    dsl,
  output logic                    bit_stb,
  output logic                    busy,
  output logic                    done
);

  localparam int         WW     = 4 * NIBBLES;
  localparam logic [2:0] K_LAST = 3'(NIBBLES - 1);

`ifdef SHIFT194_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_PAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
`endif

  // State holds the command being driven to the register in the current cycle.
  state_t          state_q, state_d;
  logic [2:0]      k_q, k_d;         // nibble index within the word
  logic [1:0]      sc_q, sc_d;       // shift count within the nibble (0..2)
  logic [WW-1:0]   word_q, word_d;
  logic [1:0]      mode_q, mode_d;   // {s1,s0}
  logic [3:0]      pnib_q, pnib_d;   // {p3,p2,p1,p0}
  logic            bit_stb_q, fin_stb_q, done_q;
  logic            final_cmd;
  logic [3:0]      nib;

  // Identify the last command of a frame; a new word may be taken on that edge.
  always_comb begin
`ifdef SHIFT194_PARITY_EN
    final_cmd = (state_q == ST_PAR);
`else
    final_cmd = (state_q == ST_SHIFT) && (sc_q == 2'd2) && (k_q == K_LAST);
`endif
    up.din_ready = (state_q == ST_IDLE) || final_cmd;
  end

  // Next-state sequencing: LOAD, then three SHIFTs, for each nibble.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sc_d    = sc_q;
    word_d  = word_q;
    case (state_q)
      ST_LOAD: begin
        state_d = ST_SHIFT;
        sc_d    = 2'd0;
      end
      ST_SHIFT: begin
        if (sc_q != 2'd2) begin
          sc_d = sc_q + 2'd1;
        end else if (k_q != K_LAST) begin
          k_d     = k_q + 3'd1;
          state_d = ST_LOAD;
        end
`ifdef SHIFT194_PARITY_EN
        else begin
          state_d = ST_PAR;
        end
`endif
      end
      default: ;
    endcase
    // Idle or end of frame: start the next word at once, otherwise go idle.
    if (up.din_ready) begin
      if (up.din_valid) begin
        state_d = ST_LOAD;
        k_d     = 3'd0;
        word_d  = up.din;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Decode the command for the next cycle so the register pins come from flops.
  always_comb begin
    mode_d = 2'b00;
    pnib_d = 4'b0000;
    nib    = 4'b0000;
    for (int i = 0; i < NIBBLES; i++) begin
      if (k_d == 3'(i)) nib = word_d[4*i +: 4];
    end
    case (state_d)
      ST_LOAD: begin
        mode_d = 2'b11;
        // The register's Q3 is out4, so bit0 goes on p3 to leave the register first.
        pnib_d = {nib[0], nib[1], nib[2], nib[3]};
      end
      ST_SHIFT: mode_d = 2'b01;
`ifdef SHIFT194_PARITY_EN
      ST_PAR: begin
        mode_d = 2'b11;
        pnib_d = {^word_d, 3'b111};
      end
`endif
      default: ;
    endcase
  end

  // State, command and strobe registers.
  always_ff @(posedge cp or negedge mr_) begin
    if (!mr_) begin
      state_q   <= ST_IDLE;
      k_q       <= 3'd0;
      sc_q      <= 2'd0;
      word_q    <= '0;
      mode_q    <= 2'b00;
      pnib_q    <= 4'b0000;
      bit_stb_q <= 1'b0;
      fin_stb_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      sc_q      <= sc_d;
      word_q    <= word_d;
      mode_q    <= mode_d;
      pnib_q    <= pnib_d;
      bit_stb_q <= (mode_q == 2'b11) || (mode_q == 2'b01);
      fin_stb_q <= final_cmd;
      done_q    <= fin_stb_q;
    end
  end

  assign s1      = mode_q[1];
  assign s0      = mode_q[0];
  assign p3      = pnib_q[3];
  assign p2      = pnib_q[2];
  assign p1      = pnib_q[1];
  assign p0      = pnib_q[0];
  assign dsr     = 1'b1;
  assign dsl     = 1'b1;
  assign bit_stb = bit_stb_q;
  assign busy    = (state_q != ST_IDLE) || bit_stb_q;
  assign done    = done_q;

endmodule

// File: doc/shift194_sequencer.md
# shift194_sequencer

Upstream controller for the 4-bit universal shift register stage. Accepts parallel words over a valid/ready handshake and drives the register's mode select (`s1`/`s0`), parallel inputs (`p0`..`p3`) and serial fill inputs (`dsr`/`dsl`). The register is driven so that `out4` emits the word as an LSB-first serial bit stream. It also produces a bit strobe for the downstream serial consumer.

## Interface
- `NIBBLES`, default 2: nibbles per word. Word width is 4*`NIBBLES`. Legal range is 1..8.
- `cp` input 1: clock, rising edge.
- `mr_` input 1: reset, asynchronous, active-low.
- `din` input 4*NIBBLES: parallel word.
- `din_valid` input 1: word offered.
- `din_ready` output 1: sequencer can accept a word.
- `s1`, `s0` output 1 each: register mode. 00 = hold, 01 = shift right, 10 = shift left (never driven), 11 = parallel load.
- `p0`..`p3` output 1 each: parallel nibble to the register.
- `dsr`, `dsl` output 1 each: serial fill. Constant 1 (mark).
- `bit_stb` output 1: a new valid bit is on the register's `out4` this cycle.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse after the last bit's strobe.

## Operation
- States:
  - IDLE: mode 00, `din_ready`=1.
  - LOAD: mode 11. Present nibble k with `p3`=bit0, `p2`=bit1, `p1`=bit2, `p0`=bit3 of nibble k.
  - SHIFT: mode 01, 3 consecutive cycles.
  - PAR: present only with the macro; see Configuration.
- Accept: `din` is captured into an internal word register on a rising `cp` where `din_valid` & `din_ready`.
  - Nibble index k resets to 0 and the next state is LOAD.
- LOAD(k) -> SHIFT. After the third SHIFT cycle:
  - if k < NIBBLES-1: k++, go to LOAD;
  - else go to PAR (macro defined) or end of frame.
- End of frame:
  - If a new word is accepted on that edge, go directly to LOAD(0).
  - Otherwise go to IDLE.
- `din_ready` is 1 in IDLE and in the final command cycle of a frame (the last SHIFT, or PAR). This allows back-to-back frames with no gap.
- `bit_stb` is a registered copy of "mode was 11 or 01 last cycle": it is high in the cycle after each load/shift command.
- `busy` = state != IDLE, or `bit_stb` still pending.
- `done` pulses in the cycle after the final `bit_stb`.
  - If a new frame starts back-to-back, `done` still pulses for the previous frame.
- Mode 10 is never emitted. `dsl` is tied 1.
- All mode, `p*` and fill outputs are registered, with no combinational path from `din`/`din_valid` to them.

## Timing
- Reset (`mr_` low), asynchronous and immediate: state IDLE; `s1`/`s0`=00; `p0`..`p3`=0; `dsr`=`dsl`=1; `bit_stb`=0; `busy`=0; `done`=0; `din_ready`=1 after release.
  - Reset mid-frame drops the in-flight word, and no `done` is generated.
- Accept at edge E0. LOAD command is driven during cycle E0..E1, and the register loads at E1.
- First `bit_stb` is in cycle E1..E2, with bit0 on `out4`.
- Frame length is 4*NIBBLES command cycles (plus 1 with the macro). Bits appear on consecutive cycles with no gaps within a frame.
- Back-to-back: the first LOAD of the next frame directly follows the final command of the current frame, so `bit_stb` stays continuously high.
- `din_valid` deasserted with `din_ready` low is a legal no-op. `din` is sampled only on the accepting edge.

## Configuration
- `SHIFT194_PARITY_EN` defined:
  - After the last SHIFT, one PAR cycle is inserted: mode 11, `p3` = even parity (XOR of all word bits), `p2`..`p0`=1.
  - Adds one `bit_stb`. Frame = 4*NIBBLES+1 bits.
- Undefined:
  - PAR does not exist. Frame = 4*NIBBLES bits.
  - No parity logic is synthesized.

## Test plan
- Reset: assert `mr_`=0 mid-SHIFT with `din`=0x3C in flight -> outputs immediately reach reset values. No `done`. After release `din_ready`=1 and `out4` activity stops.
- Single word, NIBBLES=2: `din`=0xA5, one-cycle valid -> `out4` on successive `bit_stb` cycles = 1,0,1,0,0,1,0,1. Eight strobes, then `done` pulses once.
- Mode sequence for 0xA5 -> `s1s0` = 11,01,01,01,11,01,01,01 then 00. Parallel nibbles are `p3..p0`=1010 then 0101.
- Back-to-back: `din_valid` held high with 0x0F then 0xF0 -> 16 contiguous `bit_stb` cycles giving 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1. Two `done` pulses.
- Backpressure: `din_valid` asserted while busy mid-frame -> `din_ready`=0 and no capture until the final SHIFT cycle. `din` changed before acceptance is ignored.
- `SHIFT194_PARITY_EN`: `din`=0x07 -> 9 strobes with the ninth bit 1. `din`=0xA5 -> ninth bit 0.
